// File: rtl/score_report_pkg.sv
// Shared opcodes, FSM states and result field layout for the score/event
// read-back path.
package score_report_pkg;

   localparam logic [1:0] OP_SCORES = 2'd0;
   localparam logic [1:0] OP_POP    = 2'd1;
   localparam logic [1:0] OP_CLEAR  = 2'd2;
   localparam logic [1:0] OP_STATUS = 2'd3;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StDone
   } state_t;

   // Event record: {player, frame[15:0]}
   localparam int unsigned EV_W        = 17;
   localparam int unsigned FRAME_W     = 16;
   localparam int unsigned EV_PLAYER   = 16;

   // Result word bit positions
   localparam int unsigned RES_GO_BIT     = 31;
   localparam int unsigned RES_OVF_BIT    = 30;
   localparam int unsigned RES_VALID_BIT  = 31;
   localparam int unsigned RES_PLAYER_BIT = 16;
   localparam int unsigned RES_STOVF_BIT  = 31;

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module event_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 17,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CNT_W = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_pop;
   logic             w_do_push;

   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd];
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !clear) r_mem[r_wr] <= din;
   end

endmodule

// File: rtl/score_report.sv
// Goal counting, frame-stamped event queue and start/done custom-instruction
// read-back of scores and events for the CPU.
module score_report
   import score_report_pkg::*;
#(
   parameter int unsigned SCORE_W    = 8,
   parameter int unsigned WIN_SCORE  = 10,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RST_BTN,
   input  logic        CLK_EN,
   input  logic        start,
   input  logic [1:0]  n,
   input  logic        goal_p1,
   input  logic        goal_p2,
   input  logic        frame_tick,
   output logic        done,
   output logic [31:0] result,
   output logic        game_over
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   state_t               r_state;
   logic [1:0]           r_op;
   logic                 r_done;
   logic [31:0]          r_result;
   logic [FRAME_W-1:0]   r_frame;
   logic [SCORE_W-1:0]   r_score1;
   logic [SCORE_W-1:0]   r_score2;
   logic                 r_game_over;
   logic                 r_overflow;
   logic                 r_pend_vld;
   logic [EV_W-1:0]      r_pend_ev;

   logic                 w_exec;
   logic                 w_clear;
   logic                 w_pop;
   logic                 w_g1;
   logic                 w_g2;
   logic                 w_push;
   logic [EV_W-1:0]      w_push_ev;
   logic                 w_pend_vld_d;
   logic [EV_W-1:0]      w_pend_ev_d;
   logic                 w_drop;
   logic                 w_ovf_set;
   logic [SCORE_W-1:0]   w_score1_d;
   logic [SCORE_W-1:0]   w_score2_d;
   logic [EV_W-1:0]      w_dout;
   logic                 w_full;
   logic                 w_empty;
   logic [CNT_W-1:0]     w_count;
   logic [31:0]          w_result;

   assign done      = r_done;
   assign result    = r_result;
   assign game_over = r_game_over;

   assign w_exec  = (r_state == StExec);
   assign w_clear = w_exec && (r_op == OP_CLEAR);
   assign w_pop   = w_exec && (r_op == OP_POP) && !w_empty;
   assign w_g1    = goal_p1 && !r_game_over && !w_clear;
   assign w_g2    = goal_p2 && !r_game_over && !w_clear;

   // One FIFO write port: an older pending event always goes first; a p1
   // goal arriving then takes the pending slot, a p2 goal is dropped.
   always_comb begin
      w_push       = 1'b0;
      w_push_ev    = '0;
      w_pend_vld_d = r_pend_vld;
      w_pend_ev_d  = r_pend_ev;
      w_drop       = 1'b0;
      if (w_clear) begin
         w_pend_vld_d = 1'b0;
      end else if (r_pend_vld) begin
         w_push       = 1'b1;
         w_push_ev    = r_pend_ev;
         w_pend_vld_d = w_g1;
         w_pend_ev_d  = {1'b0, r_frame};
         w_drop       = w_g2;
      end else if (w_g1) begin
         w_push       = 1'b1;
         w_push_ev    = {1'b0, r_frame};
         w_pend_vld_d = w_g2;
         w_pend_ev_d  = {1'b1, r_frame};
      end else if (w_g2) begin
         w_push       = 1'b1;
         w_push_ev    = {1'b1, r_frame};
      end
   end

   assign w_ovf_set = w_drop || (w_push && w_full && !w_pop);

   assign w_score1_d = w_clear ? '0 :
                       (w_g1 && (r_score1 < WIN)) ? r_score1 + 1'b1 : r_score1;
   assign w_score2_d = w_clear ? '0 :
                       (w_g2 && (r_score2 < WIN)) ? r_score2 + 1'b1 : r_score2;

   always_comb begin
      w_result = '0;
      unique case (r_op)
         OP_SCORES: begin
            w_result[RES_GO_BIT]  = r_game_over;
            w_result[RES_OVF_BIT] = r_overflow;
            w_result[15:8]        = 8'(r_score2);
            w_result[7:0]         = 8'(r_score1);
         end
         OP_POP: begin
            if (!w_empty) begin
               w_result[RES_VALID_BIT]  = 1'b1;
               w_result[RES_PLAYER_BIT] = w_dout[EV_PLAYER];
               w_result[15:0]           = w_dout[FRAME_W-1:0];
            end
         end
         OP_CLEAR: w_result = '0;
         OP_STATUS: begin
            w_result[RES_STOVF_BIT] = r_overflow;
            w_result[3:0]           = 4'(w_count);
         end
         default: w_result = '0;
      endcase
   end

   event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EV_W)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_BTN),
      .push  (w_push),
      .pop   (w_pop),
      .clear (w_clear),
      .din   (w_push_ev),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         r_frame     <= '0;
         r_score1    <= '0;
         r_score2    <= '0;
         r_game_over <= 1'b0;
         r_overflow  <= 1'b0;
         r_pend_vld  <= 1'b0;
         r_pend_ev   <= '0;
      end else begin
         if (frame_tick) r_frame <= r_frame + 1'b1;
         r_score1    <= w_score1_d;
         r_score2    <= w_score2_d;
         r_game_over <= !w_clear && ((w_score1_d == WIN) || (w_score2_d == WIN));
         r_overflow  <= w_clear ? 1'b0 : (r_overflow || w_ovf_set);
         r_pend_vld  <= w_pend_vld_d;
         r_pend_ev   <= w_pend_ev_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         r_state  <= StIdle;
         r_op     <= OP_SCORES;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_done <= 1'b0;
               if (start && CLK_EN) begin
                  r_op    <= n;
                  r_state <= StExec;
               end
            end
            StExec: begin
               r_result <= w_result;
               r_done   <= 1'b1;
               r_state  <= StDone;
            end
            StDone: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_score_report.sv
// Directed bench for score_report: scores, event pops, clear, overflow,
// game-over lockout, ignored starts and reset during an instruction.
module tb_score_report;

   logic        clk;
   logic        rst_btn;
   logic        clk_en;
   logic        start;
   logic [1:0]  n;
   logic        goal_p1;
   logic        goal_p2;
   logic        frame_tick;
   logic        done;
   logic [31:0] result;
   logic        game_over;

   int          total;
   int          bad;
   logic [15:0] exp_frame;

   score_report #(
      .SCORE_W    (8),
      .WIN_SCORE  (10),
      .FIFO_DEPTH (8)
   ) dut (
      .CLK        (clk),
      .RST_BTN    (rst_btn),
      .CLK_EN     (clk_en),
      .start      (start),
      .n          (n),
      .goal_p1    (goal_p1),
      .goal_p2    (goal_p2),
      .frame_tick (frame_tick),
      .done       (done),
      .result     (result),
      .game_over  (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Start at edge k, sample at the negedge after edge k+1 (done expected),
   // then sample done once more one cycle later (expected low).
   task automatic issue_op(input logic [1:0] op, output logic got_done,
                           output logic [31:0] got_res, output logic done_next);
      @(negedge clk);
      start = 1'b1; clk_en = 1'b1; n = op;
      @(negedge clk);
      start = 1'b0; clk_en = 1'b0;
      @(negedge clk);
      got_done = done; got_res = result;
      @(negedge clk);
      done_next = done;
   endtask

   task automatic goal(input logic a, input logic b);
      @(negedge clk);
      goal_p1 = a; goal_p2 = b;
      @(negedge clk);
      goal_p1 = 1'b0; goal_p2 = 1'b0;
   endtask

   task automatic tick_to(input logic [15:0] f);
      while (exp_frame != f) begin
         @(negedge clk);
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         exp_frame++;
      end
   endtask

   task automatic test_reset();
      logic d, dn; logic [31:0] r;
      rst_btn = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (done !== 1'b0 || result !== 32'h0 || game_over !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: done=%b result=%h game_over=%b, want 0 00000000 0",
                  done, result, game_over);
      end
      rst_btn = 1'b1;
      issue_op(2'd0, d, r, dn);
      total++;
      if (d !== 1'b1 || r !== 32'h0 || dn !== 1'b0) begin
         bad++;
         $display("FAIL op0_after_reset: done=%b result=%h done_next=%b, want 1 00000000 0",
                  d, r, dn);
      end
      issue_op(2'd3, d, r, dn);
      total++;
      if (d !== 1'b1 || r !== 32'h0 || dn !== 1'b0) begin
         bad++;
         $display("FAIL op3_after_reset: done=%b result=%h done_next=%b, want 1 00000000 0",
                  d, r, dn);
      end
   endtask

   task automatic test_goals();
      logic d, dn; logic [31:0] r;
      logic [31:0] exp_pop [6];
      exp_pop[0] = 32'h80000005; exp_pop[1] = 32'h80000005; exp_pop[2] = 32'h80010005;
      exp_pop[3] = 32'h80000006; exp_pop[4] = 32'h80010006; exp_pop[5] = 32'h00000000;
      tick_to(16'd5);
      goal(1'b1, 1'b0);
      goal(1'b1, 1'b0);
      goal(1'b0, 1'b1);
      tick_to(16'd6);
      goal(1'b1, 1'b0);
      goal(1'b0, 1'b1);
      issue_op(2'd0, d, r, dn);
      total++;
      if (d !== 1'b1 || r !== 32'h00000203) begin
         bad++;
         $display("FAIL goals_scores: done=%b result=%h, want 1 00000203", d, r);
      end
      for (int i = 0; i < 6; i++) begin
         issue_op(2'd1, d, r, dn);
         total++;
         if (d !== 1'b1 || r !== exp_pop[i]) begin
            bad++;
            $display("FAIL goals_pop%0d: done=%b result=%h, want 1 %h", i, d, r, exp_pop[i]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic d, dn; logic [31:0] r;
      issue_op(2'd2, d, r, dn);
      total++;
      if (d !== 1'b1 || r !== 32'h0) begin
         bad++;
         $display("FAIL simul_clear: done=%b result=%h, want 1 00000000", d, r);
      end
      tick_to(16'd9);
      goal(1'b1, 1'b1);
      issue_op(2'd1, d, r, dn);
      total++;
      if (r !== 32'h80000009) begin
         bad++;
         $display("FAIL simul_pop_p1: result=%h, want 80000009", r);
      end
      issue_op(2'd1, d, r, dn);
      total++;
      if (r !== 32'h80010009) begin
         bad++;
         $display("FAIL simul_pop_p2: result=%h, want 80010009", r);
      end
      issue_op(2'd0, d, r, dn);
      total++;
      if (r !== 32'h00000101) begin
         bad++;
         $display("FAIL simul_scores: result=%h, want 00000101", r);
      end
   endtask

   task automatic test_overflow();
      logic d, dn; logic [31:0] r;
      for (int i = 0; i < 9; i++) goal(1'b1, 1'b0);
      issue_op(2'd3, d, r, dn);
      total++;
      if (r !== 32'h80000008) begin
         bad++;
         $display("FAIL ovf_status: result=%h, want 80000008", r);
      end
      issue_op(2'd2, d, r, dn);
      issue_op(2'd3, d, r, dn);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL ovf_status_cleared: result=%h, want 00000000", r);
      end
      issue_op(2'd0, d, r, dn);
      total++;
      if (r !== 32'h0) begin
         bad++;
         $display("FAIL ovf_scores_cleared: result=%h, want 00000000", r);
      end
   endtask

   task automatic test_game_over();
      logic d, dn; logic [31:0] r;
      logic [31:0] want;
      for (int i = 0; i < 5; i++) goal(1'b0, 1'b1);
      want = {16'h8001, exp_frame};
      for (int i = 0; i < 5; i++) begin
         issue_op(2'd1, d, r, dn);
         total++;
         if (r !== want) begin
            bad++;
            $display("FAIL go_pop%0d: result=%h, want %h", i, r, want);
         end
      end
      for (int i = 0; i < 4; i++) goal(1'b0, 1'b1);
      total++;
      if (game_over !== 1'b0) begin
         bad++;
         $display("FAIL go_at_nine: game_over=%b, want 0", game_over);
      end
      goal(1'b0, 1'b1);
      total++;
      if (game_over !== 1'b1) begin
         bad++;
         $display("FAIL go_at_ten: game_over=%b, want 1", game_over);
      end
      issue_op(2'd0, d, r, dn);
      total++;
      if (r !== 32'h80000A00) begin
         bad++;
         $display("FAIL go_scores: result=%h, want 80000a00", r);
      end
      goal(1'b1, 1'b0);
      goal(1'b0, 1'b1);
      issue_op(2'd3, d, r, dn);
      total++;
      if (r !== 32'h00000005) begin
         bad++;
         $display("FAIL go_locked_count: result=%h, want 00000005", r);
      end
      issue_op(2'd0, d, r, dn);
      total++;
      if (r !== 32'h80000A00) begin
         bad++;
         $display("FAIL go_locked_scores: result=%h, want 80000a00", r);
      end
   endtask

   task automatic test_reset_mid_exec();
      int seen;
      @(negedge clk);
      start = 1'b1; clk_en = 1'b1; n = 2'd0;
      @(negedge clk);
      start = 1'b0; clk_en = 1'b0;
      rst_btn = 1'b0;
      #1;
      total++;
      if (done !== 1'b0 || result !== 32'h0 || game_over !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_exec: done=%b result=%h game_over=%b, want 0 00000000 0",
                  done, result, game_over);
      end
      exp_frame = 16'd0;
      @(negedge clk);
      rst_btn = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rst_no_done: done pulses=%0d, want 0", seen);
      end
   endtask

   task automatic test_ignored_start();
      logic d, dn; logic [31:0] r;
      int seen;
      goal(1'b1, 1'b0);
      @(negedge clk);
      start = 1'b1; clk_en = 1'b0; n = 2'd2;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      start = 1'b0;
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL clk_en_low: done pulses=%0d, want 0", seen);
      end
      @(negedge clk);
      start = 1'b1; clk_en = 1'b1; n = 2'd0;
      @(negedge clk);
      n = 2'd2;
      @(negedge clk);
      r = result;
      seen = (done === 1'b1) ? 1 : 0;
      @(negedge clk);
      start = 1'b0; clk_en = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      total++;
      if (seen != 1 || r !== 32'h00000001) begin
         bad++;
         $display("FAIL busy_start: done pulses=%0d result=%h, want 1 00000001", seen, r);
      end
      issue_op(2'd0, d, r, dn);
      total++;
      if (r !== 32'h00000001) begin
         bad++;
         $display("FAIL busy_no_clear: result=%h, want 00000001", r);
      end
   endtask

   initial begin
      total = 0; bad = 0; exp_frame = 16'd0;
      rst_btn = 1'b0; clk_en = 1'b0; start = 1'b0; n = 2'd0;
      goal_p1 = 1'b0; goal_p2 = 1'b0; frame_tick = 1'b0;
      test_reset();
      test_goals();
      test_simultaneous();
      test_overflow();
      test_game_over();
      test_reset_mid_exec();
      test_ignored_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
